// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART Tx datapath between NREQ byte requesters.
// Optional macro UART_TX_SCHED_PRIO0_EN gives requester 0 absolute priority over the round-robin.
module uart_tx_sched #(
    parameter int NREQ       = 4,
    parameter int IDW        = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk_tx,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic              cfg_d_num,
    input  logic              cfg_parity,
    input  logic              cfg_stop_bits,
    output logic              tx_enable,
    output logic [7:0]        tx_data,
    output logic              tx_d_num,
    output logic              tx_parity,
    output logic              tx_stop_bits,
    output logic [IDW-1:0]    grant_id,
    output logic              busy,
    output logic              frame_done
);
    typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;
    state_t         state, state_nx;
    logic [IDW-1:0] ptr, win, idx;
    logic           found;
    logic [3:0]     fcnt, frame_len;
    logic [7:0]     gcnt;
    // Combinational arbitration: scan from ptr+1 with wraparound, first pending requester wins
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = ptr;
        for (int i = 0; i < NREQ; i++) begin
            idx = (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
`ifdef UART_TX_SCHED_PRIO0_EN
        if (req_valid[0]) begin
            found = 1'b1;
            win   = '0;
        end
`endif
    end
    // Next-state and strobe outputs
    always_comb begin
        frame_len  = 4'd1 + (tx_d_num ? 4'd8 : 4'd7) + 4'd1 + (tx_stop_bits ? 4'd2 : 4'd1);
        req_ready  = (state == IDLE && found) ? NREQ'(1) << win : '0;
        tx_enable  = state == START;
        frame_done = state == SEND && fcnt == 4'd1;
        busy       = state != IDLE;
        state_nx   = state == IDLE  ? (found ? START : IDLE) :
                     state == START ? SEND :
                     state == SEND  ? (fcnt == 4'd1 ? (GAP_CYCLES == 0 ? IDLE : GAP) : SEND) :
                                      (gcnt == 8'd1 ? IDLE : GAP);
    end
    // State register
    always_ff @(posedge clk_tx) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end
    // Grant latch and frame/gap counters; datapath inputs only move on the grant edge
    always_ff @(posedge clk_tx) begin
        if (reset) begin
            ptr          <= IDW'(NREQ - 1);
            grant_id     <= '0;
            tx_data      <= 8'h00;
            tx_d_num     <= 1'b0;
            tx_parity    <= 1'b0;
            tx_stop_bits <= 1'b0;
            fcnt         <= 4'd0;
            gcnt         <= 8'd0;
        end else begin
            if (state == IDLE && found) begin
                ptr          <= win;
                grant_id     <= win;
                tx_data      <= req_data[8*win +: 8];
                tx_d_num     <= cfg_d_num;
                tx_parity    <= cfg_parity;
                tx_stop_bits <= cfg_stop_bits;
            end
            if (state == START) fcnt <= frame_len;
            if (state == SEND)  fcnt <= fcnt - 4'd1;
            if (state == SEND && fcnt == 4'd1) gcnt <= 8'(GAP_CYCLES);
            if (state == GAP)   gcnt <= gcnt - 8'd1;
        end
    end
endmodule
